// File: rtl/idit_ifft8_seq_if.sv
// Streaming bus for the 8-point sequential IFFT: sample input stream, sample
// output stream and the busy status flag.
// Latency: none, wires only. Backpressure: in_valid/in_ready, out_valid/out_ready.
// Ports: master = producer/consumer side, slave = IFFT block side.
interface idit_ifft8_seq_if #(
  parameter int DATA_W = 9
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     out_last;
  logic                     busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last, busy
  );
endinterface

// File: rtl/idit_ifft8_seq.sv
// 8-point radix-2 DIT inverse DFT with one shared butterfly, x[n] = (1/8) sum X[k] W8^{-kn}.
// Latency: last input accepted at edge T -> first out_valid after edge T+13.
// Backpressure: in_ready only while loading; output index holds while out_ready=0.
// Ports: clk, rst (async, active-high); io (slave): in_valid/in_ready/in_re/in_im
//        sample input X[k] in natural order; out_valid/out_ready/out_re/out_im/out_last
//        sample output x[n] in natural order; busy high while computing or outputting.
module idit_ifft8_seq #(
  parameter int DATA_W  = 9,
  parameter int TW_FRAC = 7
) (
  input  logic             clk,
  input  logic             rst,
  idit_ifft8_seq_if.slave  io
);

  localparam int SW = DATA_W + 3;     // butterfly sum width
  localparam int PW = 2 * DATA_W + 1; // full-precision complex product width
  localparam int TW = DATA_W + 2;     // width of the scaled product t

  // cos(pi/4) rounded: 181/256 ~= 0.70703
  localparam logic signed [DATA_W-1:0] TW_ONE = DATA_W'(1 << TW_FRAC);
  localparam logic signed [DATA_W-1:0] TW_R2  = DATA_W'(((1 << TW_FRAC) * 181 + 128) / 256);

  localparam logic signed [SW-1:0] SAT_MAX = {4'b0000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {4'b1111, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

  state_t     state_q, state_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic [3:0] bf_cnt_q, bf_cnt_d;
  logic [2:0] out_idx_q, out_idx_d;

  logic signed [DATA_W-1:0] mem_re_q [8];
  logic signed [DATA_W-1:0] mem_im_q [8];

  // Butterfly results are registered and written back one cycle later; this
  // breaks the multiplier-to-memory path and accounts for the extra cycle
  // between the 12th butterfly and the first output.
  logic                     wb_vld_q;
  logic [2:0]               wb_a_q, wb_b_q;
  logic signed [DATA_W-1:0] wb_a_re_q, wb_a_im_q, wb_b_re_q, wb_b_im_q;

  logic in_fire, out_fire, compute_en;

  assign in_fire    = io.in_valid && (state_q == S_LOAD);
  assign out_fire   = (state_q == S_OUTPUT) && io.out_ready;
  assign compute_en = (state_q == S_COMPUTE) && (bf_cnt_q < 4'd12);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      bf_cnt_q   <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      bf_cnt_q   <= bf_cnt_d;
      out_idx_q  <= out_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bf_cnt_d   = bf_cnt_q;
    out_idx_d  = out_idx_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          if (load_cnt_q == 3'd7) begin
            state_d    = S_COMPUTE;
            load_cnt_d = '0;
            bf_cnt_d   = '0;
          end else begin
            load_cnt_d = load_cnt_q + 3'd1;
          end
        end
      end
      S_COMPUTE: begin
        // bf_cnt 0..11 issue butterflies, 12 drains the write-back register
        if (bf_cnt_q == 4'd12) begin
          state_d   = S_OUTPUT;
          bf_cnt_d  = '0;
          out_idx_d = '0;
        end else begin
          bf_cnt_d = bf_cnt_q + 4'd1;
        end
      end
      S_OUTPUT: begin
        if (out_fire) begin
          if (out_idx_q == 3'd7) begin
            state_d    = S_LOAD;
            out_idx_d  = '0;
            load_cnt_d = '0;
          end else begin
            out_idx_d = out_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // ---------------- Butterfly addressing ----------------
  // Stage s has span 2^s; butterfly j pairs (a, a+span) where a inserts a zero
  // at bit s of j, and the twiddle exponent is (a mod span) * (4/span).
  logic [1:0] stage, bfly, tw_m;
  logic [2:0] a_addr, b_addr, span;

  assign stage = bf_cnt_q[3:2];
  assign bfly  = bf_cnt_q[1:0];

  always_comb begin
    a_addr = '0;
    span   = '0;
    tw_m   = '0;
    case (stage)
      2'd0: begin
        a_addr = {bfly, 1'b0};
        span   = 3'd1;
        tw_m   = 2'd0;
      end
      2'd1: begin
        a_addr = {bfly[1], 1'b0, bfly[0]};
        span   = 3'd2;
        tw_m   = {bfly[0], 1'b0};
      end
      default: begin
        a_addr = {1'b0, bfly};
        span   = 3'd4;
        tw_m   = bfly;
      end
    endcase
  end

  assign b_addr = a_addr + span;

  // Conjugate twiddles W8^{-m} = e^{+j*pi*m/4}
  logic signed [DATA_W-1:0] w_re, w_im;

  always_comb begin
    w_re = TW_ONE;
    w_im = '0;
    case (tw_m)
      2'd0: begin w_re = TW_ONE; w_im = '0;     end
      2'd1: begin w_re = TW_R2;  w_im = TW_R2;  end
      2'd2: begin w_re = '0;     w_im = TW_ONE; end
      default: begin w_re = -TW_R2; w_im = TW_R2; end
    endcase
  end

  // ---------------- Butterfly datapath ----------------
  logic signed [DATA_W-1:0]   a_re, a_im, b_re, b_im;
  logic signed [2*DATA_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]       t_re_full, t_im_full;
  logic signed [TW-1:0]       t_re, t_im;
  logic signed [SW-1:0]       sum_a_re, sum_a_im, sum_b_re, sum_b_im;

  assign a_re = mem_re_q[a_addr];
  assign a_im = mem_im_q[a_addr];
  assign b_re = mem_re_q[b_addr];
  assign b_im = mem_im_q[b_addr];

  assign p_rr = b_re * w_re;
  assign p_ii = b_im * w_im;
  assign p_ri = b_re * w_im;
  assign p_ir = b_im * w_re;

  assign t_re_full = p_rr - p_ii;
  assign t_im_full = p_ri + p_ir;

  // Selecting bits above TW_FRAC is the floor (arithmetic) shift; |t| stays
  // within TW bits for any DATA_W-bit operands and |w| <= 1.
  assign t_re = t_re_full[TW_FRAC +: TW];
  assign t_im = t_im_full[TW_FRAC +: TW];

  assign sum_a_re = a_re + t_re;
  assign sum_a_im = a_im + t_im;
  assign sum_b_re = a_re - t_re;
  assign sum_b_im = a_im - t_im;

  // Halve with floor, then clamp to the signed DATA_W range
  function automatic logic signed [DATA_W-1:0] half_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] h;
    h = s >>> 1;
    if (h > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (h < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return h[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld_q  <= 1'b0;
      wb_a_q    <= '0;
      wb_b_q    <= '0;
      wb_a_re_q <= '0;
      wb_a_im_q <= '0;
      wb_b_re_q <= '0;
      wb_b_im_q <= '0;
    end else begin
      wb_vld_q <= compute_en;
      if (compute_en) begin
        wb_a_q    <= a_addr;
        wb_b_q    <= b_addr;
        wb_a_re_q <= half_sat(sum_a_re);
        wb_a_im_q <= half_sat(sum_a_im);
        wb_b_re_q <= half_sat(sum_b_re);
        wb_b_im_q <= half_sat(sum_b_im);
      end
    end
  end

  // Sample memory: loaded in bit-reversed order, updated in place. Not reset;
  // every word is rewritten by a full frame before it can be output.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re_q[{load_cnt_q[0], load_cnt_q[1], load_cnt_q[2]}] <= io.in_re;
      mem_im_q[{load_cnt_q[0], load_cnt_q[1], load_cnt_q[2]}] <= io.in_im;
    end else if (wb_vld_q) begin
      mem_re_q[wb_a_q] <= wb_a_re_q;
      mem_im_q[wb_a_q] <= wb_a_im_q;
      mem_re_q[wb_b_q] <= wb_b_re_q;
      mem_im_q[wb_b_q] <= wb_b_im_q;
    end
  end

  // ---------------- Outputs ----------------
  assign io.in_ready  = (state_q == S_LOAD);
  assign io.out_valid = (state_q == S_OUTPUT);
  assign io.out_last  = (state_q == S_OUTPUT) && (out_idx_q == 3'd7);
  assign io.busy      = (state_q != S_LOAD);
  assign io.out_re    = (state_q == S_OUTPUT) ? mem_re_q[out_idx_q] : '0;
  assign io.out_im    = (state_q == S_OUTPUT) ? mem_im_q[out_idx_q] : '0;

endmodule

// File: tb/tb_idit_ifft8_seq.sv
// Self-checking bench for idit_ifft8_seq: table of directed frames plus
// hand-written backpressure, back-to-back and reset sequences.
module tb_idit_ifft8_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idit_ifft8_seq_if #(.DATA_W(9)) bus ();

  idit_ifft8_seq #(.DATA_W(9), .TW_FRAC(7)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string           name;
    logic [7:0][8:0] xr;
    logic [7:0][8:0] xi;
    logic [7:0][8:0] er;
    logic [7:0][8:0] ei;
  } vec_t;

  vec_t tv [5];

  int z8       [8] = '{default: 0};
  int all8     [8] = '{default: 8};
  int allm8    [8] = '{default: -8};
  int all64    [8] = '{default: 64};
  int imp_x    [8] = '{64, 0, 0, 0, 0, 0, 0, 0};
  int nimp_x   [8] = '{-64, 0, 0, 0, 0, 0, 0, 0};
  int tone_x   [8] = '{0, 64, 0, 0, 0, 0, 0, 0};
  int tone_er  [8] = '{8, 5, 0, -6, -8, -6, 0, 6};
  int tone_ei  [8] = '{0, 5, 8, 5, 0, -6, -8, -6};
  int tone2_x  [8] = '{0, 0, 64, 0, 0, 0, 0, 0};
  int tone2_er [8] = '{8, 0, -8, 0, 8, 0, -8, 0};
  int tone2_ei [8] = '{0, 8, 0, -8, 0, 8, 0, -8};

  int t7, t8, tx7;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input string nm, input int xr[8], input int xi[8],
                         input int er[8], input int ei[8]);
    tv[i].name = nm;
    for (int k = 0; k < 8; k++) begin
      tv[i].xr[k] = 9'(xr[k]);
      tv[i].xi[k] = 9'(xi[k]);
      tv[i].er[k] = 9'(er[k]);
      tv[i].ei[k] = 9'(ei[k]);
    end
  endtask

  task automatic load_frame(input int v);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_re    = tv[v].xr[k];
      bus.in_im    = tv[v].xi[k];
      chk($sformatf("%s in_ready k%0d", tv[v].name, k), int'(bus.in_ready), 1);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int n);
    n = 0;
    while (!bus.out_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic read_frame(input int v);
    int g;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_out(40, g);
      chk($sformatf("%s out_valid x%0d", tv[v].name, n), int'(bus.out_valid), 1);
      chk($sformatf("%s re x%0d", tv[v].name, n), int'(bus.out_re), int'($signed(tv[v].er[n])));
      chk($sformatf("%s im x%0d", tv[v].name, n), int'(bus.out_im), int'($signed(tv[v].ei[n])));
      chk($sformatf("%s last x%0d", tv[v].name, n), int'(bus.out_last), (n == 7) ? 1 : 0);
      step();
    end
    chk($sformatf("%s in_ready after x7", tv[v].name), int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat, n, g, r;

    set_vec(0, "impulse",      imp_x,   z8,     all8,     z8);
    set_vec(1, "constant",     all64,   z8,     imp_x,    z8);
    set_vec(2, "tone1",        tone_x,  z8,     tone_er,  tone_ei);
    set_vec(3, "tone2",        tone2_x, z8,     tone2_er, tone2_ei);
    set_vec(4, "imag_impulse", z8,      nimp_x, z8,       allm8);

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("reset in_ready",  int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_last",  int'(bus.out_last), 0);
    chk("reset busy",      int'(bus.busy), 0);
    chk("reset out_re",    int'(bus.out_re), 0);
    chk("reset out_im",    int'(bus.out_im), 0);

    // Directed frames
    for (int i = 0; i < 5; i++) begin
      load_frame(i);
      chk($sformatf("%s busy in compute", tv[i].name), int'(bus.busy), 1);
      chk($sformatf("%s in_ready in compute", tv[i].name), int'(bus.in_ready), 0);
      wait_out(40, lat);
      chk($sformatf("%s latency", tv[i].name), lat, 13);
      read_frame(i);
    end

    // Output backpressure with random stalls
    load_frame(2);
    wait_out(40, lat);
    n = 0;
    g = 0;
    while (n < 8 && g < 200) begin
      r = (g == 0) ? 0 : int'($urandom_range(0, 1));
      bus.out_ready = r[0];
      chk($sformatf("bp valid x%0d", n), int'(bus.out_valid), 1);
      chk($sformatf("bp re x%0d", n), int'(bus.out_re), tone_er[n]);
      chk($sformatf("bp im x%0d", n), int'(bus.out_im), tone_ei[n]);
      chk($sformatf("bp last x%0d", n), int'(bus.out_last), (n == 7) ? 1 : 0);
      chk($sformatf("bp in_ready x%0d", n), int'(bus.in_ready), 0);
      step();
      if (r != 0) n++;
      g++;
    end
    chk("bp all outputs taken", n, 8);
    chk("bp in_ready after x7", int'(bus.in_ready), 1);

    // Back-to-back frames with in_valid held high for 16 samples
    t7  = 0;
    t8  = 0;
    tx7 = 0;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          int gd;
          bus.in_valid = 1'b1;
          bus.in_re    = (k < 8) ? tv[0].xr[k] : tv[2].xr[k-8];
          bus.in_im    = (k < 8) ? tv[0].xi[k] : tv[2].xi[k-8];
          gd = 0;
          while (!bus.in_ready && gd < 60) begin
            step();
            gd++;
          end
          if (k == 7) t7 = cyc + 1;
          if (k == 8) t8 = cyc + 1;
          step();
        end
        bus.in_valid = 1'b0;
      end
      begin
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
          int gc, vi, nn;
          vi = (i < 8) ? 0 : 2;
          nn = i % 8;
          gc = 0;
          while (!bus.out_valid && gc < 60) begin
            step();
            gc++;
          end
          if (i == 0) chk("b2b latency", cyc - t7, 13);
          chk($sformatf("b2b f%0d re x%0d", i / 8, nn), int'(bus.out_re), int'($signed(tv[vi].er[nn])));
          chk($sformatf("b2b f%0d im x%0d", i / 8, nn), int'(bus.out_im), int'($signed(tv[vi].ei[nn])));
          chk($sformatf("b2b f%0d last x%0d", i / 8, nn), int'(bus.out_last), (nn == 7) ? 1 : 0);
          if (i == 7) tx7 = cyc + 1;
          step();
        end
      end
    join
    chk("b2b reload gap", t8 - tx7, 1);

    // Reset in the middle of COMPUTE
    load_frame(0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("rst compute out_valid", int'(bus.out_valid), 0);
    chk("rst compute busy",      int'(bus.busy), 0);
    chk("rst compute out_re",    int'(bus.out_re), 0);
    step();
    rst = 1'b0;
    step();
    chk("rst compute in_ready after", int'(bus.in_ready), 1);
    chk("rst compute out_valid after", int'(bus.out_valid), 0);

    // Reset in the middle of OUTPUT
    load_frame(2);
    wait_out(40, lat);
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("mid output valid before rst", int'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst output out_valid", int'(bus.out_valid), 0);
    chk("rst output out_last",  int'(bus.out_last), 0);
    chk("rst output out_re",    int'(bus.out_re), 0);
    chk("rst output out_im",    int'(bus.out_im), 0);
    step();
    rst = 1'b0;
    step();
    chk("rst output in_ready after", int'(bus.in_ready), 1);
    chk("rst output busy after",     int'(bus.busy), 0);

    // A full frame after reset still produces correct results
    load_frame(0);
    wait_out(40, lat);
    chk("post-reset latency", lat, 13);
    read_frame(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idit_ifft8_seq.md
IDIT_IFFT8_SEQ -- requirements
Module: idit_ifft8_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 9, sample width (two's complement, integer) per real/imag part.
REQ-002 SHALL have parameter TW_FRAC, default 7, twiddle fractional bits; twiddle width DATA_W.
REQ-003 SHALL have clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have in_valid  in  1  input sample valid.
REQ-006 SHALL have in_ready  out  1  block accepts input sample.
REQ-007 SHALL have in_re, in_im  in  DATA_W each  frequency-domain sample X[k], k in natural order.
REQ-008 SHALL have out_valid  out  1  output sample valid.
REQ-009 SHALL have out_ready  in  1  downstream accepts output sample.
REQ-010 SHALL have out_re, out_im  out  DATA_W each  time-domain sample x[n], n in natural order.
REQ-011 SHALL have out_last  out  1  high with x[7].
REQ-012 SHALL have busy  out  1  high in COMPUTE and OUTPUT states.

Function
REQ-013 SHALL implement an 8-point radix-2 decimation-in-time inverse DFT, x[n] = (1/8)·sum X[k]·e^{+j2πkn/8}, with one shared butterfly reused over time.
REQ-014 SHALL use FSM states LOAD, COMPUTE, OUTPUT; LOAD -> COMPUTE on 8th accepted input; COMPUTE -> OUTPUT after 12 butterfly cycles; OUTPUT -> LOAD on accepted x[7].
REQ-015 SHALL assert in_ready only in LOAD; sample accepted when in_valid && in_ready; sample k written to 8-entry complex memory at bitrev3(k).
REQ-016 SHALL run COMPUTE as 3 stages × 4 butterflies, one per cycle; stage s (span 1,2,4) pairs addresses (a, a+span), twiddle W8^{-m}, m = (a mod span)·(4/span).
REQ-017 SHALL use conjugate (inverse) twiddles with TW_FRAC=7: W^0=(128,0), W^-1=(91,91), W^-2=(0,128), W^-3=(-91,91).
REQ-018 SHALL compute t = w·b as re=(br·wr − bi·wi)>>>TW_FRAC, im=(br·wi + bi·wr)>>>TW_FRAC, full-precision products, arithmetic (floor) shift.
REQ-019 SHALL write a' = (a + t)>>>1, b' = (a − t)>>>1 in place, sums at DATA_W+3 bits, result saturated to DATA_W signed range; the three halvings provide the 1/8 scaling.
REQ-020 SHALL, in OUTPUT, present memory entry n (n = 0..7) with out_valid=1; advance n only when out_valid && out_ready; hold out_re/out_im/out_last stable while out_ready=0.
REQ-021 SHALL have fixed latency: last input accepted at edge T -> out_valid first high in cycle after edge T+13 (12 compute cycles + 1 transition cycle).
REQ-022 SHALL ignore in_valid while busy; no input is lost or stored outside LOAD.
REQ-023 SHALL allow next frame's first input in the cycle after x[7] is accepted (back-to-back frames, no idle gap required).
REQ-024 SHALL keep load count, butterfly count and output index as 3-, 4-, 3-bit counters cleared on every state entry.

Reset
REQ-025 SHALL on rst (any state, any cycle, mid-frame included) go to LOAD, clear all counters, out_valid=0, out_last=0, busy=0, in_ready=1 the cycle after release, out_re=out_im=0; partial frame discarded.
REQ-026 SHALL not require memory contents to be cleared by reset; no memory word is output before being rewritten by a full frame.

Verification
REQ-027 Impulse: X[0]=(64,0), X[1..7]=0 -> x[0..7] all (8,0); out_last only with x[7].
REQ-028 Constant: X[k]=(64,0) all k -> x[0]=(64,0), x[1..7]=(0,0).
REQ-029 Single tone: X[1]=(64,0), others 0 -> x[0]=(8,0), x[1]=(5,5), x[2]=(0,8), x[3]=(-6,5), x[4]=(-8,0), x[5]=(-6,-6), x[6]=(0,-8), x[7]=(6,-6).
REQ-030 Backpressure: out_ready toggled randomly during OUTPUT -> same 8 values in order, outputs stable while stalled, in_ready=0 until x[7] accepted.
REQ-031 Latency/back-to-back: in_valid held high for 16 samples -> out_valid rises exactly 13 cycles after 8th input edge; second frame loads immediately after first x[7] accepted.
REQ-032 Reset mid-COMPUTE and mid-OUTPUT -> outputs zero, in_ready=1 after release; next full frame (REQ-027 stimulus) yields correct results.
